// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared command codes, FSM states and default widths for mem_arbiter
package mem_pkg;

    localparam int DEFAULT_AW = 9;
    localparam int DEFAULT_DW = 16;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDRESP = 2'd2
    } state_t;

    // 2'b11 is not a command; it is treated the same as MNONE.
    function automatic logic is_cmd(input logic [1:0] cmd);
        return (cmd == MREAD) || (cmd == MWRITE);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - two-way round-robin winner selection
// Ports:
//   req0, req1  - valid command present on port 0 / port 1
//   last_grant  - port granted by the previous transaction
//   grant       - winning port id (only meaningful when req0 | req1)
module rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant
);

    // On a tie the port that did not win last time is chosen; otherwise the
    // sole requester wins.
    assign grant = (req0 && req1) ? ~last_grant : req1;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter in front of a single synchronous-read RAM
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   mX_cmd/mX_addr/mX_wdata       - requester command, address, write data
//   mX_ack                        - pulse in the cycle the request is issued to RAM
//   mX_rdata/mX_rvalid            - per-port read data and its one-cycle valid
//   ram_addr/ram_wdata/ram_write  - RAM request (write enable only in ACCESS)
//   ram_rdata                     - RAM read data, one cycle after the address
//   busy                          - high whenever the FSM is not IDLE
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW = DEFAULT_AW,
    parameter int DW = DEFAULT_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    m0_cmd,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [1:0]    m1_cmd,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_ack,
    output logic          m1_ack,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_write,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    state_t        r_state;
    state_t        w_next;
    logic          r_id;
    logic [1:0]    r_cmd;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_last_grant;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic w_req0;
    logic w_req1;
    logic w_any;
    logic w_pick;
    logic w_access;
    logic w_rdresp;

    assign w_req0 = is_cmd(m0_cmd);
    assign w_req1 = is_cmd(m1_cmd);
    assign w_any  = w_req0 | w_req1;

    rr_pick u_rr_pick (
        .req0       (w_req0),
        .req1       (w_req1),
        .last_grant (r_last_grant),
        .grant      (w_pick)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any ? ACCESS : IDLE;
            ACCESS:  w_next = (r_cmd == MWRITE) ? IDLE : RDRESP;
            RDRESP:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_id         <= 1'b0;
            r_cmd        <= MNONE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_last_grant <= 1'b1;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) begin
                r_id    <= w_pick;
                r_cmd   <= w_pick ? m1_cmd   : m0_cmd;
                r_addr  <= w_pick ? m1_addr  : m0_addr;
                r_wdata <= w_pick ? m1_wdata : m0_wdata;
            end
            if (w_access) begin
                r_last_grant <= r_id;
            end
            if (m0_rvalid) begin
                r_rdata0 <= ram_rdata;
            end
            if (m1_rvalid) begin
                r_rdata1 <= ram_rdata;
            end
        end
    end

    assign w_access = (r_state == ACCESS);
    assign w_rdresp = (r_state == RDRESP);

    assign m0_ack    = w_access & ~r_id;
    assign m1_ack    = w_access &  r_id;
    assign m0_rvalid = w_rdresp & ~r_id;
    assign m1_rvalid = w_rdresp &  r_id;

    // RAM data only arrives in RDRESP, so the winner's port bypasses its
    // register that cycle to present the data alongside rvalid; the register
    // captures it at the same edge and holds it afterwards.
    assign m0_rdata = m0_rvalid ? ram_rdata : r_rdata0;
    assign m1_rdata = m1_rvalid ? ram_rdata : r_rdata1;

    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign ram_write = w_access && (r_cmd == MWRITE);
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard testbench for mem_arbiter
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    m0_cmd = MNONE, m1_cmd = MNONE;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_ack, m1_ack, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_write;
    logic [DW-1:0] ram_rdata = '0;
    logic          busy;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m1_ack(m1_ack),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_write(ram_write),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_wr20 = 0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_write) begin
            mem[ram_addr] <= ram_wdata;
            if (ram_addr == 9'h020) n_wr20 <= n_wr20 + 1;
        end
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        int            cyc;
        bit            rv;
        bit            port;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] other;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic ev_t mk_ack(input int c, input bit p, input bit wr,
                                   input logic [AW-1:0] a, input logic [DW-1:0] d);
        ev_t e;
        e.cyc = c; e.rv = 1'b0; e.port = p; e.wr = wr; e.addr = a; e.data = d; e.other = '0;
        return e;
    endfunction

    function automatic ev_t mk_rv(input int c, input bit p,
                                  input logic [DW-1:0] d, input logic [DW-1:0] o);
        ev_t e;
        e.cyc = c; e.rv = 1'b1; e.port = p; e.wr = 1'b0; e.addr = '0; e.data = d; e.other = o;
        return e;
    endfunction

    // Monitor: pops one expected event whenever the DUT presents an ack or rvalid.
    always @(negedge clk) begin
        int  n_act;
        ev_t e;
        n_act = int'(m0_ack) + int'(m1_ack) + int'(m0_rvalid) + int'(m1_rvalid);
        if (n_act > 1) begin
            chk("one_event_per_cycle", 32'(n_act), 32'd1);
        end else if (n_act == 1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {28'd0, m0_ack, m1_ack, m0_rvalid, m1_rvalid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("event_cycle", 32'(cyc), 32'(e.cyc));
                chk("event_kind", 32'(m0_rvalid | m1_rvalid), 32'(e.rv));
                chk("event_port", 32'(m1_ack | m1_rvalid), 32'(e.port));
                if (!e.rv) begin
                    chk("ack_ram_write", 32'(ram_write), 32'(e.wr));
                    chk("ack_ram_addr", 32'(ram_addr), 32'(e.addr));
                    if (e.wr) chk("ack_ram_wdata", 32'(ram_wdata), 32'(e.data));
                end else begin
                    chk("rvalid_rdata", 32'(e.port ? m1_rdata : m0_rdata), 32'(e.data));
                    chk("rvalid_other_rdata", 32'(e.port ? m0_rdata : m1_rdata), 32'(e.other));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;

        // Reset state
        tick(3);
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ram_write", 32'(ram_write), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_m0_rdata", 32'(m0_rdata), 32'd0);
        chk("rst_m1_rdata", 32'(m1_rdata), 32'd0);
        chk("rst_pulses", {28'd0, m0_ack, m1_ack, m0_rvalid, m1_rvalid}, 32'd0);

        // Single write from m0
        t = cyc;
        m0_cmd = MWRITE; m0_addr = 9'h005; m0_wdata = 16'hABCD;
        exp_q.push_back(mk_ack(t + 1, 1'b0, 1'b1, 9'h005, 16'hABCD));
        tick(1);
        chk("wr_busy_access", 32'(busy), 32'd1);
        m0_cmd = MNONE;
        tick(1);
        chk("wr_busy_after", 32'(busy), 32'd0);

        // Single read from m1
        t = cyc;
        m1_cmd = MREAD; m1_addr = 9'h005;
        exp_q.push_back(mk_ack(t + 1, 1'b1, 1'b0, 9'h005, 16'h0));
        exp_q.push_back(mk_rv(t + 2, 1'b1, 16'hABCD, 16'h0000));
        tick(1);
        m1_cmd = MNONE;
        tick(1);
        chk("rd_ram_write_rdresp", 32'(ram_write), 32'd0);
        tick(1);
        chk("rd_m1_rdata_held", 32'(m1_rdata), 32'hABCD);
        chk("rd_m0_rdata_unchanged", 32'(m0_rdata), 32'd0);

        // Withdrawal: one-cycle MWRITE from m1
        t = cyc;
        m1_cmd = MWRITE; m1_addr = 9'h020; m1_wdata = 16'h5A5A;
        exp_q.push_back(mk_ack(t + 1, 1'b1, 1'b1, 9'h020, 16'h5A5A));
        tick(1);
        m1_cmd = MNONE;
        tick(4);
        chk("withdraw_write_count", 32'(n_wr20), 32'd1);
        chk("withdraw_ram_data", 32'(mem[9'h020]), 32'h5A5A);

        // Tie after reset: strict alternation m0, m1, m0, m1
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        t = cyc;
        m0_cmd = MREAD; m0_addr = 9'h005;
        m1_cmd = MREAD; m1_addr = 9'h020;
        exp_q.push_back(mk_ack(t + 1,  1'b0, 1'b0, 9'h005, 16'h0));
        exp_q.push_back(mk_rv (t + 2,  1'b0, 16'hABCD, 16'h0000));
        exp_q.push_back(mk_ack(t + 4,  1'b1, 1'b0, 9'h020, 16'h0));
        exp_q.push_back(mk_rv (t + 5,  1'b1, 16'h5A5A, 16'hABCD));
        exp_q.push_back(mk_ack(t + 7,  1'b0, 1'b0, 9'h005, 16'h0));
        exp_q.push_back(mk_rv (t + 8,  1'b0, 16'hABCD, 16'h5A5A));
        exp_q.push_back(mk_ack(t + 10, 1'b1, 1'b0, 9'h020, 16'h0));
        exp_q.push_back(mk_rv (t + 11, 1'b1, 16'h5A5A, 16'hABCD));
        tick(11);
        m0_cmd = MNONE; m1_cmd = MNONE;
        tick(2);
        chk("tie_busy_after", 32'(busy), 32'd0);

        // Reset in ACCESS of an m0 read
        t = cyc;
        m0_cmd = MREAD; m0_addr = 9'h005;
        exp_q.push_back(mk_ack(t + 1, 1'b0, 1'b0, 9'h005, 16'h0));
        tick(1);
        reset = 1'b1;
        m0_cmd = MNONE;
        tick(1);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_m0_rdata", 32'(m0_rdata), 32'd0);
        chk("rstmid_ram_write", 32'(ram_write), 32'd0);
        reset = 1'b0;
        tick(1);
        t = cyc;
        m0_cmd = MWRITE; m0_addr = 9'h030; m0_wdata = 16'h1111;
        m1_cmd = MWRITE; m1_addr = 9'h031; m1_wdata = 16'h2222;
        exp_q.push_back(mk_ack(t + 1, 1'b0, 1'b1, 9'h030, 16'h1111));
        exp_q.push_back(mk_ack(t + 3, 1'b1, 1'b1, 9'h031, 16'h2222));
        tick(3);
        m0_cmd = MNONE; m1_cmd = MNONE;
        tick(2);
        chk("rstmid_tie_m0_mem", 32'(mem[9'h030]), 32'h1111);
        chk("rstmid_tie_m1_mem", 32'(mem[9'h031]), 32'h2222);

        // Illegal command 2'b11 held for 5 cycles
        m0_cmd = 2'b11; m0_addr = 9'h040; m0_wdata = 16'hDEAD;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("illegal_busy", 32'(busy), 32'd0);
            chk("illegal_ram_write", 32'(ram_write), 32'd0);
        end
        m0_cmd = MNONE;
        tick(3);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("withdraw_write_count_final", 32'(n_wr20), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 9, address width in bits.
REQ-002 Parameter DW, default 16, data width in bits.
REQ-003 The block SHALL use one clock, clk, and reset is synchronous and active-high, named reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 m0_cmd, m1_cmd  input  2 each  requester command: MNONE, MREAD or MWRITE; 2'b11 counts as MNONE.
REQ-007 m0_addr, m1_addr  input  AW each  requester address.
REQ-008 m0_wdata, m1_wdata  input  DW each  requester write data.
REQ-009 m0_ack, m1_ack  output  1 each  one-cycle pulse; request accepted and issued to RAM.
REQ-010 m0_rdata, m1_rdata  output  DW each  registered read data per port.
REQ-011 m0_rvalid, m1_rvalid  output  1 each  one-cycle pulse; mX_rdata updated this cycle.
REQ-012 ram_addr  output  AW  RAM address.
REQ-013 ram_wdata  output  DW  RAM write data.
REQ-014 ram_write  output  1  RAM write enable.
REQ-015 ram_rdata  input  DW  synchronous-read RAM data, valid one cycle after address is presented.
REQ-016 busy  output  1  high when state is not IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS, RDRESP.
REQ-018 IDLE: if any valid command is present, pick a winner, latch its id, cmd, addr and wdata, and go to ACCESS. Otherwise stay in IDLE.
REQ-019 Winner selection: a sole requester wins. On a tie, the port not recorded in last_grant wins.
REQ-020 ACCESS: ram_addr equals the latched addr, ram_wdata equals the latched wdata, and ram_write equals 1 only for MWRITE. The winner's ack is pulsed, and last_grant is updated to the winner.
REQ-021 ACCESS exit: go to IDLE after a write; go to RDRESP after a read.
REQ-022 RDRESP: the winner's rdata register loads ram_rdata and its rvalid pulses. The other port's rdata is held. Next state is IDLE.
REQ-023 Latency, with the request first sampled in IDLE at cycle T:
- ack at T+1;
- RAM written at the end of T+1;
- rvalid at T+2.
REQ-024 Throughput: one write per 2 cycles; one read per 3 cycles.
REQ-025 Commands are sampled only in IDLE. Requesters hold cmd, addr and wdata until ack; changes while not in IDLE are ignored.
REQ-026 A command withdrawn after latching still completes, with ack and, for a read, rvalid.
REQ-027 Outside ACCESS, ram_write SHALL be 0. ram_addr and ram_wdata hold the latched values.
REQ-028 At most one ack and at most one rvalid are high in any cycle.
REQ-029 A requester holding its command continuously against a continuous competitor SHALL be served within two transactions (strict alternation).

Reset
REQ-030 On reset:
- state = IDLE;
- last_grant = 1, so m0 wins the first tie;
- latched id, cmd, addr and wdata = 0;
- m0_rdata and m1_rdata = 0;
- all acks, rvalids, ram_write and busy = 0.
REQ-031 Reset asserted in ACCESS or RDRESP SHALL abort the transaction. No ack or rvalid is issued after the reset edge, and ram_write is 0 in the cycle following reset.

Structure
REQ-032 Shared package mem_pkg SHALL hold:
- MNONE=2'b00, MREAD=2'b01, MWRITE=2'b10;
- state encodings IDLE, ACCESS, RDRESP;
- default AW and DW.
REQ-033 Winner selection SHALL be a combinational sub-module rr_pick, with inputs req0, req1 and last_grant and output the winner id.
REQ-034 All remaining logic (FSM, latches, output registers) is in mem_arbiter; the RAM is external.

Verification
REQ-035 Single write: m0 issues MWRITE addr 9'h005, wdata 16'hABCD in IDLE. Required: m0_ack at T+1 with ram_write=1 and ram_addr=5; busy low at T+2.
REQ-036 Single read: m1 issues MREAD addr 5 after REQ-035. Required: m1_ack at T+1, m1_rvalid at T+2 with m1_rdata=16'hABCD, and m0_rdata unchanged.
REQ-037 Tie after reset: both ports issue MREAD simultaneously and hold. Required acks in order m0, m1, m0, m1, each read 3 cycles apart.
REQ-038 Withdrawal: m1 issues MWRITE for one cycle, then cmd=MNONE. Required: m1_ack still pulses and the RAM is written once.
REQ-039 Reset mid-read: reset asserted in ACCESS of an m0 read. Required: no m0_rvalid, state IDLE, m0_rdata=0, and the next tie goes to m0.
REQ-040 Illegal command: m0_cmd=2'b11 held for 5 cycles. Required: no ack, busy stays 0, ram_write stays 0.
